// File: rtl/stream_reorderer_pkg.sv
// rtl/stream_reorderer_pkg.sv - shared mode and packet-state types for the stream reorderer
package stream_reorderer_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_BITREV  = 2'd1,
        MODE_GRPREV  = 2'd2,
        MODE_FULLREV = 2'd3
    } reorder_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_INPKT = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/stream_permuter.sv
// rtl/stream_permuter.sv - combinational bit/group permutation of one beat
module stream_permuter
    import stream_reorderer_pkg::*;
#(
    parameter int GROUP  = 8,
    parameter int GROUPS = 4
) (
    input  reorder_mode_t            mode,
    input  logic [GROUP*GROUPS-1:0]  dat,
    output logic [GROUP*GROUPS-1:0]  perm
);

    localparam int WIDTH = GROUP * GROUPS;

    logic [WIDTH-1:0] bit_rev;
    logic [WIDTH-1:0] grp_rev;
    logic [WIDTH-1:0] full_rev;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar b = 0; b < GROUP; b++) begin : g_bit
            assign bit_rev[g*GROUP+b] = dat[g*GROUP+GROUP-1-b];
            assign grp_rev[g*GROUP+b] = dat[(GROUPS-1-g)*GROUP+b];
        end
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_full
        assign full_rev[k] = dat[WIDTH-1-k];
    end

    always_comb begin
        perm = dat;
        case (mode)
            MODE_BITREV:  perm = bit_rev;
            MODE_GRPREV:  perm = grp_rev;
            MODE_FULLREV: perm = full_rev;
            default:      perm = dat;
        endcase
    end

endmodule

// File: rtl/stream_reorderer.sv
// rtl/stream_reorderer.sv - per-packet mode switching reorder stage with registered output and skid buffer
module stream_reorderer
    import stream_reorderer_pkg::*;
#(
    parameter int GROUP  = 8,
    parameter int GROUPS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               i_mode,
    input  logic                     i_mode_upd,
    output logic [1:0]               o_mode,
    input  logic [GROUP*GROUPS-1:0]  i_dat,
    input  logic                     i_eop,
    input  logic                     i_val,
    output logic                     i_rdy,
    output logic [GROUP*GROUPS-1:0]  o_dat,
    output logic                     o_eop,
    output logic                     o_val,
    input  logic                     o_rdy
);

    localparam int WIDTH = GROUP * GROUPS;

    pkt_state_t       state_q, state_d;
    reorder_mode_t    active_mode, pend_mode, eff_mode;
    logic             pend_val;

    logic             main_val, skid_val;
    logic [WIDTH-1:0] main_dat, skid_dat, perm_dat;
    logic             main_eop, skid_eop;

    logic             accept, drain;

    assign i_rdy  = !skid_val;
    assign accept = i_val && i_rdy;
    assign drain  = main_val && o_rdy;

    assign o_val  = main_val;
    assign o_dat  = main_dat;
    assign o_eop  = main_eop;
    assign o_mode = active_mode;

    // A pending mode only takes over at a packet boundary.
    assign eff_mode = (pend_val && state_q == ST_IDLE) ? pend_mode : active_mode;

    stream_permuter #(
        .GROUP  (GROUP),
        .GROUPS (GROUPS)
    ) u_permuter (
        .mode (eff_mode),
        .dat  (i_dat),
        .perm (perm_dat)
    );

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = i_eop ? ST_IDLE : ST_INPKT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A same-cycle update lands after the boundary apply, so it is kept for the next packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_mode <= MODE_PASS;
            pend_mode   <= MODE_PASS;
            pend_val    <= 1'b0;
        end else begin
            if (accept && state_q == ST_IDLE) begin
                active_mode <= eff_mode;
                pend_val    <= 1'b0;
            end
            if (i_mode_upd) begin
                pend_val  <= 1'b1;
                pend_mode <= reorder_mode_t'(i_mode);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_val <= 1'b0;
            main_dat <= '0;
            main_eop <= 1'b0;
            skid_val <= 1'b0;
            skid_dat <= '0;
            skid_eop <= 1'b0;
        end else if (drain) begin
            if (skid_val) begin
                main_dat <= skid_dat;
                main_eop <= skid_eop;
                skid_val <= 1'b0;
            end else if (accept) begin
                main_dat <= perm_dat;
                main_eop <= i_eop;
            end else begin
                main_val <= 1'b0;
            end
        end else if (!main_val) begin
            if (accept) begin
                main_val <= 1'b1;
                main_dat <= perm_dat;
                main_eop <= i_eop;
            end
        end else if (accept) begin
            skid_val <= 1'b1;
            skid_dat <= perm_dat;
            skid_eop <= i_eop;
        end
    end

endmodule
